// File: rtl/bcd_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
// Master drives the request side; slave returns status and the registered result.
interface bcd_serial_addsub_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, sub, a, b, cin,
        input  ready, busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, sub, a, b, cin,
        output ready, busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional macro BCD_SERIAL_SAT_EN: add-mode overflow saturates the sum to all 9s.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_serial_addsub_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-digit 9's complement, 4-bit wrap for non-BCD digits.
    function automatic logic [W-1:0] nines_comp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'd9 - v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic any_invalid(input logic [W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Returns {carry, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y,
                                                 input logic c);
        logic [4:0] t;
        logic [4:0] s;
        t = {1'b0, x} + {1'b0, y} + {4'd0, c};
        if (t > 5'd9) begin
            s = t + 5'd6;
            return {1'b1, s[3:0]};
        end else begin
            return {1'b0, t[3:0]};
        end
    endfunction

    state_t          state_r, state_next_s;
    logic [W-1:0]    a_sh_r, b_sh_r, res_sh_r;
    logic            carry_r, inv_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    sum_r;
    logic            cout_r, invalid_r;
    logic            ready_r, busy_r, done_r;
    logic [4:0]      digit_s;
    logic [W+3:0]    res_cat_s;
    logic [W-1:0]    res_next_s;
    logic            last_digit_s;
`ifdef BCD_SERIAL_SAT_EN
    logic            sub_r;
`endif

    // Current digit arithmetic and the result shifted in at the MSD end.
    always_comb begin
        digit_s      = bcd_digit_add(a_sh_r[3:0], b_sh_r[3:0], carry_r);
        res_cat_s    = {digit_s[3:0], res_sh_r};
        res_next_s   = res_cat_s[W+3:4];
        last_digit_s = (cnt_r == CW'(DIGITS - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_digit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they align with state_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_next_s == IDLE);
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture, digit-serial datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            res_sh_r  <= '0;
            carry_r   <= 1'b0;
            inv_r     <= 1'b0;
            cnt_r     <= '0;
            sum_r     <= '0;
            cout_r    <= 1'b0;
            invalid_r <= 1'b0;
`ifdef BCD_SERIAL_SAT_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= bus.sub ? nines_comp(bus.b) : bus.b;
                        carry_r  <= bus.sub ? 1'b1 : bus.cin;
                        res_sh_r <= '0;
                        cnt_r    <= '0;
                        inv_r    <= any_invalid(bus.a) | any_invalid(bus.b);
`ifdef BCD_SERIAL_SAT_EN
                        sub_r    <= bus.sub;
`endif
                    end
                end
                RUN: begin
                    a_sh_r   <= a_sh_r >> 4'd4;
                    b_sh_r   <= b_sh_r >> 4'd4;
                    res_sh_r <= res_next_s;
                    carry_r  <= digit_s[4];
                    cnt_r    <= cnt_r + CW'(1'b1);
                    if (last_digit_s) begin
`ifdef BCD_SERIAL_SAT_EN
                        sum_r <= (!sub_r && digit_s[4]) ? {DIGITS{4'h9}} : res_next_s;
`else
                        sum_r <= res_next_s;
`endif
                        cout_r    <= digit_s[4];
                        invalid_r <= inv_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.sum     = sum_r;
    assign bus.cout    = cout_r;
    assign bus.invalid = invalid_r;
endmodule
